// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared types and constants for the sequential multiplier.
//   mult_state_t : FSM state encoding (IDLE, RUN, DONE), 2 bits
//   DEFAULT_WIDTH: default operand width
//   RST_STATE    : state loaded on reset
`timescale 1ns/1ps
package seq_mult_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam mult_state_t RST_STATE = IDLE;
endpackage

// File: rtl/mult_step.sv
// mult_step: one combinational shift-and-add iteration.
//   acc, mcand  : 2*WIDTH-bit accumulator and shifted multiplicand
//   mplier      : WIDTH-bit multiplier, consumed LSB first
//   *_nxt       : values after this iteration
`timescale 1ns/1ps
module mult_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);
  // Partial products never exceed the 2*WIDTH-bit result, so no carry out.
  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;
endmodule

// File: rtl/seq_mult_8bit.sv
// seq_mult_8bit: multi-cycle shift-and-add multiplier with start/busy/done.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : request a multiply, only looked at in IDLE
//   a, b       : operands, captured on the accepting edge
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse, product valid
//   product    : 2*WIDTH-bit result, held until the next result lands
// Build option: define SEQ_MULT_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied, sign applied on entry to DONE).
`timescale 1ns/1ps
module seq_mult_8bit
  import seq_mult_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  mult_state_t          state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, mcand, acc_nxt, mcand_nxt, result;
  logic [WIDTH-1:0]     mplier, mplier_nxt;
  logic [WIDTH-1:0]     a_ld, b_ld;
  logic                 last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;
  // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct magnitude
  // when read as unsigned.
  assign a_ld   = a[WIDTH-1] ? -a : a;
  assign b_ld   = b[WIDTH-1] ? -b : b;
  assign result = neg ? -acc_nxt : acc_nxt;

  always_ff @(posedge clk) begin
    if (reset)                    neg <= 1'b0;
    else if (state == IDLE && start) neg <= a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign a_ld   = a;
  assign b_ld   = b;
  assign result = acc_nxt;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RST_STATE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          mcand  <= {{WIDTH{1'b0}}, a_ld};
          mplier <= b_ld;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + CNT_W'(1);
          // Final iteration: publish the result straight from the step logic
          // so product is valid in the DONE cycle.
          if (last) product <= result;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule
